// File: rtl/booth_mult_pipe.sv
// Radix-4 Booth multiplier with a three-stage valid/ready pipeline:
// partial-product generation, carry-save reduction, then a final carry-propagate add.
module booth_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2 + 1;

    logic             adv;
    logic             v1_q, v2_q, v3_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [PW-1:0]    pp_d [NDIG];
    logic [PW-1:0]    pp_q [NDIG];
    logic [PW-1:0]    corr_d, corr_q;
    logic [PW-1:0]    sum_d, carry_d, sum_q, carry_q;
    logic [PW-1:0]    prod_d, prod_q;
    logic [PW-1:0]    a_ext;
    logic [WIDTH+2:0] b_pad;
    logic [PW-1:0]    mag;
    logic             neg;
    logic [2:0]       trip;

    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {s, c};
    endfunction

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign product   = prod_q;
    assign out_tag   = tag3_q;

    // B is extended by two bits and padded with the implicit B[-1]=0 at the bottom.
    // In signed mode the extension bits equal the sign, so the top digit is always 0.
    always_comb begin
        a_ext  = signed_mode ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                             : {{WIDTH{1'b0}}, multiplicand};
        b_pad  = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                             : {2'b00, multiplier, 1'b0};
        corr_d = '0;
        mag    = '0;
        neg    = 1'b0;
        trip   = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            trip = b_pad[2*i +: 3];
            mag  = '0;
            neg  = 1'b0;
            case (trip)
                3'b001, 3'b010: mag = a_ext;
                3'b011:         mag = a_ext << 1;
                3'b100: begin   mag = a_ext << 1; neg = 1'b1; end
                3'b101, 3'b110: begin mag = a_ext; neg = 1'b1; end
                default:        mag = '0;
            endcase
            // Negative digits: one's complement here, the +1 rides in corr_d at weight 4^i.
            pp_d[i]      = (neg ? ~mag : mag) << (2 * i);
            corr_d[2*i]  = neg;
        end
    end

    always_comb begin
        sum_d   = pp_q[0];
        carry_d = pp_q[1];
        for (int unsigned k = 2; k < NDIG; k++) begin
            {sum_d, carry_d} = csa(sum_d, carry_d, pp_q[k]);
        end
        {sum_d, carry_d} = csa(sum_d, carry_d, corr_q);
    end

    assign prod_d = sum_q + carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            pp_q    <= '{default: '0};
            corr_q  <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            prod_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                tag1_q <= in_tag;
                pp_q   <= pp_d;
                corr_q <= corr_d;
            end
            if (v1_q) begin
                tag2_q  <= tag1_q;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
            if (v2_q) begin
                tag3_q <= tag2_q;
                prod_q <= prod_d;
            end
        end
    end

endmodule

// File: doc/booth_mult_pipe.md
BOOTH_MULT_PIPE -- requirements
Module: booth_mult_pipe

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; SHALL be even and at least 4.
REQ-002 Parameter: TAG_W, 4, width of the user tag carried alongside each operation.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  operand set present.
REQ-006 Port: in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port: multiplicand  input  WIDTH  operand A.
REQ-008 Port: multiplier  input  WIDTH  operand B.
REQ-009 Port: signed_mode  input  1  1 = both operands two's complement; 0 = both unsigned.
REQ-010 Port: in_tag  input  TAG_W  user tag, captured with the operands.
REQ-011 Port: out_valid  output  1  result present.
REQ-012 Port: out_ready  input  1  downstream accepts the result.
REQ-013 Port: product  output  2*WIDTH  full-width product; signed or unsigned per captured signed_mode.
REQ-014 Port: out_tag  output  TAG_W  tag of the operation currently on product.

Function
REQ-015 The datapath SHALL be a 3-stage pipeline:
  - S1: radix-4 Booth encode and partial-product generation, registered.
  - S2: carry-save (3:2 compressor) reduction to a sum/carry pair, registered.
  - S3: final carry-propagate add, registered into product.
REQ-016 Booth digits SHALL use triplets {B[2i+1], B[2i], B[2i-1]}, with B[-1] = 0:
  - 000 and 111 -> 0
  - 001 and 010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101 and 110 -> -A
REQ-017 Each partial product SHALL be sign-extended to 2*WIDTH bits and weighted by 4^i. Negation SHALL be one's complement plus a correction bit injected in the reduction; no separate adder is used.
REQ-018 Operand extension by mode:
  - signed_mode = 0: A and B zero-extended to WIDTH+2 bits, giving WIDTH/2+1 digits.
  - signed_mode = 1: A and B sign-extended, and the extra digit evaluates to 0.
REQ-019 product SHALL equal A*B modulo 2^(2*WIDTH), exact for all operand values in both modes.
REQ-020 Each stage SHALL carry a valid bit, and signed_mode/tag SHALL travel with their data.
REQ-021 Transfer rules:
  - Input handshake occurs when in_valid && in_ready.
  - Output handshake occurs when out_valid && out_ready.
REQ-022 Advance and stall:
  - The pipeline SHALL advance when !out_valid || out_ready.
  - in_ready SHALL equal that advance condition.
  - While stalled, all stage registers hold, so product/out_tag stay stable while out_valid=1 && out_ready=0.
REQ-023 Bubbles (stage valid = 0) SHALL advance freely during advance cycles; empty stages SHALL NOT block.
REQ-024 Latency and throughput:
  - Latency SHALL be exactly 3 cycles from input handshake to out_valid when out_ready is held 1.
  - Throughput SHALL be one result per cycle.
REQ-025 Results SHALL emerge in acceptance order. No operation SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 Simultaneous output handshake and input handshake in the same cycle SHALL be legal and SHALL not lose data.
REQ-027 Inputs SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-028 On rst_n=0, immediately and independent of clk:
  - all stage valid bits SHALL clear;
  - out_valid=0;
  - product=0;
  - out_tag=0.
REQ-029 in_ready SHALL be 1 during reset and after reset release.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no stale result SHALL appear after release.
REQ-031 The first input handshake after release SHALL produce out_valid exactly 3 cycles later.

Verification (WIDTH=16)
REQ-032 Signed, out_ready=1: A=0x0007, B=0xFFFD (-3), tag=5 -> 3 cycles later product=0xFFFFFFEB, out_tag=5.
REQ-033 Corner cases:
  - Signed, A=B=0x8000 -> product=0x40000000.
  - Unsigned, A=B=0xFFFF -> product=0xFFFE0001.
  - Signed, A=B=0xFFFF -> product=0x00000001.
REQ-034 Back-to-back, out_ready=1: 4 ops, tags 0..3, A=i+1, B=2 -> products 2,4,6,8 on consecutive cycles in tag order.
REQ-035 Backpressure, with the pipeline holding 3 ops:
  - out_ready=0 for 5 cycles -> in_ready=0, product/out_tag held stable.
  - Then out_ready=1 -> 3 results released with no loss or duplicate.
REQ-036 Reset mid-operation: assert rst_n=0 with 2 ops in flight -> out_valid=0 and product=0 immediately; after release no result for those ops appears.
REQ-037 Random: 10^5 random A, B, signed_mode with random in_valid/out_ready -> every product matches a reference model, tags in order.
